// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states, ALU/mux selects.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    RESET_S   = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EX   = 4'd11,
    ADDI_WB   = 4'd12
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> datapath control decode; FETCH loads gate on mem_ready.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only advance once the fetched word is actually there
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR, ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ADDI_WB: ctrl.reg_write = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control: state register, next-state sequencing, retire counter.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_source,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  state_e state, state_nxt;
  logic   retire;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_S;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    retire    = 1'b0;
    case (state)
      RESET_S:   state_nxt = FETCH;
      FETCH:     state_nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_LW, OP_SW: state_nxt = MEM_ADDR;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
          OP_ADDI:      state_nxt = ADDI_EX;
          default:      state_nxt = FETCH;
        endcase
      end
      MEM_ADDR:  state_nxt = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_nxt = mem_ready ? MEM_WB : MEM_READ;
      MEM_WB:    retire    = 1'b1;
      MEM_WRITE: begin
        state_nxt = mem_ready ? FETCH : MEM_WRITE;
        retire    = mem_ready;
      end
      EXECUTE:   state_nxt = R_WB;
      R_WB:      retire    = 1'b1;
      BRANCH:    retire    = 1'b1;
      JUMP:      retire    = 1'b1;
      ADDI_EX:   state_nxt = ADDI_WB;
      ADDI_WB:   retire    = 1'b1;
      // unused encodings fall back to FETCH without retiring anything
      default:   state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
  end

  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign illegal_op    = (state == DECODE) && !op_legal(opcode);

endmodule
